// File: rtl/pic_priority_scheduler.sv
// Priority scheduler for an 8-input PIC core.
// Picks the winning IR line from masked IRR against the In-Service register using a
// rotating priority ring, raises o_int_req, runs the two-pulse INTA handshake, keeps the
// ISR and executes OCW2 EOI / rotate commands.
//
// Optional feature macro: PIC_SPECIAL_MASK_EN (adds i_smm, OCW3 special mask mode).
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      synchronous reset, active low
//   i_irr        masked interrupt requests, bit i = IRi
//   i_ack1       1-cycle pulse, first INTA
//   i_ack2       1-cycle pulse, second INTA
//   i_aeoi       automatic EOI mode
//   i_ocw2       OCW2 byte {R,SL,EOI,0,0,L2,L1,L0}
//   i_ocw2_wr    1-cycle strobe qualifying i_ocw2
//   i_smm        special mask mode (only with PIC_SPECIAL_MASK_EN)
//   o_int_req    interrupt request to CPU / master
//   o_int_vec    IR index of the acknowledged interrupt
//   o_isr        In-Service register
//   o_irr_clr    one-hot 1-cycle pulse clearing the acknowledged IR edge latch
//   o_spurious   high from ack1 until IDLE when nothing was pending at ack1
module pic_priority_scheduler #(
  parameter logic [2:0]  RESET_LP    = 3'd7,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_irr,
  input  logic       i_ack1,
  input  logic       i_ack2,
  input  logic       i_aeoi,
  input  logic [7:0] i_ocw2,
  input  logic       i_ocw2_wr,
`ifdef PIC_SPECIAL_MASK_EN
  input  logic       i_smm,
`endif
  output logic       o_int_req,
  output logic [2:0] o_int_vec,
  output logic [7:0] o_isr,
  output logic [7:0] o_irr_clr,
  output logic       o_spurious
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0] RANK_NONE = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2
  } state_t;

  // Rank (0 = highest priority) of the first set bit walking the ring from lp+1; 8 if none.
  function automatic logic [3:0] first_rank(input logic [7:0] v, input logic [2:0] lp);
    logic [3:0] rank;
    logic [2:0] idx;
    rank = RANK_NONE;
    for (int k = 7; k >= 0; k--) begin
      idx = 3'(lp + 3'd1 + 3'(k));
      if (v[idx]) rank = 4'(k);
    end
    return rank;
  endfunction

  state_t           r_state;
  logic             r_int_req;
  logic [2:0]       r_int_vec;
  logic [7:0]       r_isr;
  logic [7:0]       r_irr_clr;
  logic             r_spurious;
  logic [2:0]       r_lp;
  logic             r_rot_aeoi;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic             w_int_req_nxt;
  logic [2:0]       w_int_vec_nxt;
  logic [7:0]       w_isr_nxt;
  logic [7:0]       w_irr_clr_nxt;
  logic             w_spurious_nxt;
  logic [2:0]       w_lp_nxt;
  logic             w_rot_aeoi_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [7:0] w_irr_eff;
  logic [3:0] w_block_rank;
  logic [3:0] w_irr_rank;
  logic [3:0] w_isr_rank;
  logic       w_win_valid;
  logic [2:0] w_win_idx;
  logic       w_isr_any;
  logic [2:0] w_isr_top;
  logic [2:0] w_ocw2_l;
  logic [7:0] w_isr_eoi;
  logic [7:0] w_isr_set;
  logic [7:0] w_isr_aeoi_clr;
  logic       w_ocw2_unused;

  assign w_ocw2_l      = i_ocw2[2:0];
  assign w_ocw2_unused = ^i_ocw2[4:3];

  // Winner: highest-priority request strictly above the highest in-service level.
  always_comb begin
    w_isr_rank = first_rank(r_isr, r_lp);
`ifdef PIC_SPECIAL_MASK_EN
    // Special mask: only a line's own ISR bit blocks it.
    w_irr_eff    = i_smm ? (i_irr & ~r_isr) : i_irr;
    w_block_rank = i_smm ? RANK_NONE : w_isr_rank;
`else
    w_irr_eff    = i_irr;
    w_block_rank = w_isr_rank;
`endif
    w_irr_rank  = first_rank(w_irr_eff, r_lp);
    w_win_valid = (w_irr_rank < w_block_rank);
    w_win_idx   = 3'(r_lp + 3'd1 + w_irr_rank[2:0]);
    w_isr_any   = ~w_isr_rank[3];
    w_isr_top   = 3'(r_lp + 3'd1 + w_isr_rank[2:0]);
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_int_req_nxt  = r_int_req;
    w_int_vec_nxt  = r_int_vec;
    w_irr_clr_nxt  = 8'h00;
    w_spurious_nxt = r_spurious;
    w_lp_nxt       = r_lp;
    w_rot_aeoi_nxt = r_rot_aeoi;
    w_cnt_nxt      = r_cnt;
    w_isr_eoi      = r_isr;
    w_isr_set      = 8'h00;
    w_isr_aeoi_clr = 8'h00;

    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_int_req_nxt = 1'b1;
          w_state_nxt   = ST_REQ;
        end
      end
      ST_REQ: begin
        // Request is held even if the winner vanishes: the CPU has already committed.
        if (i_ack1) begin
          w_int_req_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_ACK1;
          if (w_win_valid) begin
            w_int_vec_nxt          = w_win_idx;
            w_isr_set[w_win_idx]   = 1'b1;
            w_irr_clr_nxt          = 8'b1 << w_win_idx;
            w_spurious_nxt         = 1'b0;
          end else begin
            w_int_vec_nxt  = 3'd7;
            w_spurious_nxt = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (i_ack2) begin
          w_state_nxt    = ST_IDLE;
          w_spurious_nxt = 1'b0;
          w_cnt_nxt      = '0;
          if (i_aeoi && !r_spurious) begin
            w_isr_aeoi_clr[r_int_vec] = 1'b1;
            if (r_rot_aeoi) w_lp_nxt = r_int_vec;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_spurious_nxt = 1'b0;
          w_cnt_nxt      = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_int_req_nxt = 1'b0;
      end
    endcase

    // OCW2 commands; an explicit priority write overrides an AEOI rotation in the same cycle.
    if (i_ocw2_wr) begin
      case (i_ocw2[7:5])
        3'b001: if (w_isr_any) w_isr_eoi[w_isr_top] = 1'b0;
        3'b011: w_isr_eoi[w_ocw2_l] = 1'b0;
        3'b101: begin
          if (w_isr_any) begin
            w_isr_eoi[w_isr_top] = 1'b0;
            w_lp_nxt             = w_isr_top;
          end
        end
        3'b111: begin
          w_isr_eoi[w_ocw2_l] = 1'b0;
          w_lp_nxt            = w_ocw2_l;
        end
        3'b110: w_lp_nxt = w_ocw2_l;
        3'b100: w_rot_aeoi_nxt = 1'b1;
        3'b000: w_rot_aeoi_nxt = 1'b0;
        default: ;
      endcase
    end

    // EOI clears apply first, so an ack1 set on the same bit wins.
    w_isr_nxt = (w_isr_eoi & ~w_isr_aeoi_clr) | w_isr_set;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_int_req  <= 1'b0;
      r_int_vec  <= 3'd0;
      r_isr      <= 8'h00;
      r_irr_clr  <= 8'h00;
      r_spurious <= 1'b0;
      r_lp       <= RESET_LP;
      r_rot_aeoi <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_int_req  <= w_int_req_nxt;
      r_int_vec  <= w_int_vec_nxt;
      r_isr      <= w_isr_nxt;
      r_irr_clr  <= w_irr_clr_nxt;
      r_spurious <= w_spurious_nxt;
      r_lp       <= w_lp_nxt;
      r_rot_aeoi <= w_rot_aeoi_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign o_int_req  = r_int_req;
  assign o_int_vec  = r_int_vec;
  assign o_isr      = r_isr;
  assign o_irr_clr  = r_irr_clr;
  assign o_spurious = r_spurious;

endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Self-checking bench for pic_priority_scheduler: directed scenarios plus randomized
// handshakes checked against a ring-priority reference model.
module tb_pic_priority_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic       ack1;
  logic       ack2;
  logic       aeoi;
  logic [7:0] ocw2;
  logic       ocw2_wr;
`ifdef PIC_SPECIAL_MASK_EN
  logic       smm;
`endif
  logic       int_req;
  logic [2:0] int_vec;
  logic [7:0] isr;
  logic [7:0] irr_clr;
  logic       spurious;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [7:0] m_isr;
  int       m_lp;
  bit       m_rot;

  pic_priority_scheduler dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_irr     (irr),
    .i_ack1    (ack1),
    .i_ack2    (ack2),
    .i_aeoi    (aeoi),
    .i_ocw2    (ocw2),
    .i_ocw2_wr (ocw2_wr),
`ifdef PIC_SPECIAL_MASK_EN
    .i_smm     (smm),
`endif
    .o_int_req (int_req),
    .o_int_vec (int_vec),
    .o_isr     (isr),
    .o_irr_clr (irr_clr),
    .o_spurious(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Walk priorities from lp+1 around the ring; an in-service level at or above blocks.
  function automatic int m_winner(bit [7:0] r, bit [7:0] s, int lp);
    for (int p = 1; p <= 8; p++) begin
      int idx;
      idx = (lp + p) % 8;
      if (s[idx]) return -1;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int m_top(bit [7:0] s, int lp);
    for (int p = 1; p <= 8; p++) begin
      if (s[(lp + p) % 8]) return (lp + p) % 8;
    end
    return -1;
  endfunction

  task automatic model_ocw2(input bit [7:0] b);
    int t;
    int l;
    l = int'(b[2:0]);
    t = m_top(m_isr, m_lp);
    case (b[7:5])
      3'b001: if (t >= 0) m_isr[t] = 1'b0;
      3'b011: m_isr[l] = 1'b0;
      3'b101: if (t >= 0) begin m_isr[t] = 1'b0; m_lp = t; end
      3'b111: begin m_isr[l] = 1'b0; m_lp = l; end
      3'b110: m_lp = l;
      3'b100: m_rot = 1'b1;
      3'b000: m_rot = 1'b0;
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ocw2(input bit [7:0] b);
    ocw2 = b; ocw2_wr = 1'b1;
    step();
    ocw2_wr = 1'b0; ocw2 = 8'h00;
    model_ocw2(b);
    checks++;
    if (isr !== m_isr) begin
      errors++;
      $display("FAIL ocw2_%02h_isr: got %02h expected %02h", b, isr, m_isr);
    end
  endtask

  // Full handshake from IDLE with irr_v; ends in IDLE with irr=0.
  task automatic do_irq(input bit [7:0] irr_v, input bit aeoi_v);
    int w;
    irr = irr_v; aeoi = aeoi_v;
    w = m_winner(irr_v, m_isr, m_lp);
    step();
    checks++;
    if (int_req !== (w >= 0)) begin
      errors++;
      $display("FAIL irq_req irr=%02h isr=%02h lp=%0d: got %b expected %b",
               irr_v, m_isr, m_lp, int_req, (w >= 0));
    end
    if (w < 0 || int_req !== 1'b1) begin
      irr = 8'h00;
      return;
    end
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    irr  = 8'h00;
    m_isr[w] = 1'b1;
    checks++;
    if (int_req !== 1'b0 || int_vec !== 3'(w) || irr_clr !== (8'h01 << w) || isr !== m_isr) begin
      errors++;
      $display("FAIL irq_ack1: req=%b vec=%0d clr=%02h isr=%02h expected req=0 vec=%0d clr=%02h isr=%02h",
               int_req, int_vec, irr_clr, isr, w, 8'h01 << w, m_isr);
    end
    step();
    checks++;
    if (irr_clr !== 8'h00) begin
      errors++;
      $display("FAIL irq_clr_pulse: got %02h expected 00", irr_clr);
    end
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
    if (aeoi_v) begin
      m_isr[w] = 1'b0;
      if (m_rot) m_lp = w;
    end
    checks++;
    if (isr !== m_isr || int_req !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack2: isr=%02h req=%b expected isr=%02h req=0", isr, int_req, m_isr);
    end
    aeoi = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irr = 8'h00; ack1 = 0; ack2 = 0; aeoi = 0; ocw2 = 8'h00; ocw2_wr = 0;
`ifdef PIC_SPECIAL_MASK_EN
    smm = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    m_isr = 8'h00; m_lp = 7; m_rot = 1'b0;
    checks++;
    if ({int_req, int_vec, isr, irr_clr, spurious} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b vec=%0d isr=%02h clr=%02h spur=%b expected all 0",
               int_req, int_vec, isr, irr_clr, spurious);
    end
  endtask

  task automatic test_nested();
    do_irq(8'h24, 1'b0);                 // IR2 wins, isr=04
    irr = 8'h08;
    step(); step();
    checks++;
    if (int_req !== 1'b0) begin
      errors++;
      $display("FAIL nested_block: got int_req=%b expected 0", int_req);
    end
    irr = 8'h00;
    do_irq(8'h01, 1'b0);                 // IR0 preempts, isr=05
    do_ocw2(8'h20);                      // non-specific EOI -> 04
    do_ocw2(8'hC3);                      // lp=3
    do_irq(8'h11, 1'b0);                 // IR4 wins
    checks++;
    if (int_vec !== 3'd4) begin
      errors++;
      $display("FAIL rotate_vec: got %0d expected 4", int_vec);
    end
    do_ocw2(8'h62);
    do_ocw2(8'h64);
    do_ocw2(8'hC7);
  endtask

  task automatic test_aeoi_rotate();
    do_irq(8'h80, 1'b1);
    do_ocw2(8'hA0);
    do_ocw2(8'h80);                      // rot_aeoi=1
    do_irq(8'h08, 1'b1);                 // lp becomes 3
    do_irq(8'h11, 1'b1);                 // IR4 now highest
    checks++;
    if (int_vec !== 3'd4 || m_lp != 4) begin
      errors++;
      $display("FAIL aeoi_rotate: vec=%0d lp_model=%0d expected vec=4 lp=4", int_vec, m_lp);
    end
    do_ocw2(8'h00);
    do_ocw2(8'hC7);
  endtask

  task automatic test_spurious_timeout();
    irr = 8'h80;
    step();
    irr = 8'h00;
    step();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL req_hold: got %b expected 1", int_req);
    end
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    checks++;
    if (spurious !== 1'b1 || int_vec !== 3'd7 || isr !== m_isr || irr_clr !== 8'h00 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack: spur=%b vec=%0d isr=%02h clr=%02h req=%b expected 1 7 %02h 00 0",
               spurious, int_vec, isr, irr_clr, int_req, m_isr);
    end
    repeat (14) step();
    checks++;
    if (spurious !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: spurious=%b expected 1 after 14 cycles", spurious);
    end
    step();
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL timeout_exit: spurious=%b expected 0 after 15 cycles", spurious);
    end
    // Real interrupt, then timeout: ISR bit is kept and a late ack2 is ignored.
    irr = 8'h02;
    step();
    ack1 = 1'b1;
    step();
    ack1 = 1'b0; irr = 8'h00;
    m_isr[1] = 1'b1;
    repeat (15) step();
    aeoi = 1'b1; ack2 = 1'b1;
    step();
    ack2 = 1'b0; aeoi = 1'b0;
    checks++;
    if (isr !== m_isr) begin
      errors++;
      $display("FAIL timeout_isr_held: got %02h expected %02h", isr, m_isr);
    end
    do_ocw2(8'h61);
  endtask

  task automatic test_ocw2_ack1_same_cycle();
    irr = 8'h02;
    step();
    ack1 = 1'b1; ack2 = 1'b1; ocw2 = 8'h61; ocw2_wr = 1'b1;
    step();
    ack1 = 1'b0; ack2 = 1'b0; ocw2_wr = 1'b0; ocw2 = 8'h00; irr = 8'h00;
    model_ocw2(8'h61);
    m_isr[1] = 1'b1;
    checks++;
    if (isr !== m_isr || int_vec !== 3'd1) begin
      errors++;
      $display("FAIL ocw2_ack1_same: isr=%02h vec=%0d expected isr=%02h vec=1", isr, int_vec, m_isr);
    end
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
    do_ocw2(8'h61);
  endtask

  task automatic test_reset_mid_handshake();
    irr = 8'h01;
    step();
    ack1 = 1'b1;
    step();
    ack1 = 1'b0; irr = 8'h00;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_isr = 8'h00; m_lp = 7; m_rot = 1'b0;
    checks++;
    if ({int_req, int_vec, isr, irr_clr, spurious} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid: req=%b vec=%0d isr=%02h clr=%02h spur=%b expected all 0",
               int_req, int_vec, isr, irr_clr, spurious);
    end
  endtask

  task automatic test_random();
    bit [7:0] cmds [8];
    cmds[0] = 8'h20; cmds[1] = 8'h60; cmds[2] = 8'hA0; cmds[3] = 8'hE0;
    cmds[4] = 8'hC0; cmds[5] = 8'h80; cmds[6] = 8'h00; cmds[7] = 8'h40;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        bit [7:0] c;
        c = cmds[$urandom_range(0, 7)] | 8'($urandom_range(0, 7));
        do_ocw2(c);
      end
      do_irq(8'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_nested();
    test_aeoi_rotate();
    test_spurious_timeout();
    test_ocw2_ack1_same_cycle();
    test_random();
    test_reset_mid_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
